// File: rtl/n_bit_divider_pkg.sv
// rtl/n_bit_divider_pkg.sv - shared arithmetic constants and divider state encoding
package n_bit_divider_pkg;

    localparam int DEFAULT_N = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/n_bit_divider_if.sv
// rtl/n_bit_divider_if.sv - start/done request and result bundle for the divider
interface n_bit_divider_if import n_bit_divider_pkg::*; #(
    parameter int N = DEFAULT_N
) ();

    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/n_bit_divider_trial_sub.sv
// rtl/n_bit_divider_trial_sub.sv - (N+1)-bit trial subtractor, neg flags a failed trial
module n_bit_trial_sub #(
    parameter int N = 64
) (
    input  logic [N:0] a,
    input  logic [N:0] b,
    output logic [N:0] diff,
    output logic       neg
);

    assign diff = a - b;
    assign neg  = diff[N];

endmodule

// File: rtl/n_bit_divider.sv
// rtl/n_bit_divider.sv - sequential unsigned restoring divider, one quotient bit per cycle
module n_bit_divider import n_bit_divider_pkg::*; #(
    parameter int N = DEFAULT_N
) (
    input  logic            clk,
    input  logic            rst_n,
    n_bit_divider_if.slave  bus
);

    localparam int CW = $clog2(N);

    div_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] dvnd_q, dvnd_d;
    logic [N-1:0] dvsr_q, dvsr_d;
    logic [N-1:0] r_q, r_d;
    logic [N-1:0] q_acc_q, q_acc_d;
    logic [N-1:0] quotient_q, quotient_d;
    logic [N-1:0] remainder_q, remainder_d;
    logic         dbz_q, dbz_d;
    logic         zero_pend_q, zero_pend_d;

    logic [N:0]   trial;
    logic [N:0]   sub_diff;
    logic         sub_neg;
    logic         unused_diff_msb;

    assign trial = {r_q, q_acc_q[N-1]};

    n_bit_trial_sub #(.N(N)) u_trial_sub (
        .a    (trial),
        .b    ({1'b0, dvsr_q}),
        .diff (sub_diff),
        .neg  (sub_neg)
    );

    assign unused_diff_msb = sub_diff[N];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvnd_d      = dvnd_q;
        dvsr_d      = dvsr_q;
        r_d         = r_q;
        q_acc_d     = q_acc_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        zero_pend_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                // A zero divisor spends one non-busy cycle here so its result lands one edge after acceptance
                if (zero_pend_q) begin
                    state_d     = DONE;
                    quotient_d  = '1;
                    remainder_d = dvnd_q;
                    dbz_d       = 1'b1;
                end else if (bus.start) begin
                    dvnd_d      = bus.dividend;
                    dvsr_d      = bus.divisor;
                    quotient_d  = '0;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    if (bus.divisor == '0) begin
                        zero_pend_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        r_d     = '0;
                        q_acc_d = bus.dividend;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                r_d     = sub_neg ? trial[N-1:0] : sub_diff[N-1:0];
                q_acc_d = {q_acc_q[N-2:0], ~sub_neg};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d     = DONE;
                    quotient_d  = q_acc_d;
                    remainder_d = r_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvnd_q      <= '0;
            dvsr_q      <= '0;
            r_q         <= '0;
            q_acc_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            zero_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvnd_q      <= dvnd_d;
            dvsr_q      <= dvsr_d;
            r_q         <= r_d;
            q_acc_q     <= q_acc_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            zero_pend_q <= zero_pend_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
